// File: rtl/game_ctrl_if.sv
// Signal bundle between game_ctrl and its neighbours: the button pulses, collision
// events and score_tracker in one direction, and the gated events and display values back.
interface game_ctrl_if;
  logic       start;
  logic       pause;
  logic       frameTick;
  logic       goodColl_i;
  logic       badColl_i;
  logic [6:0] curScore;
  logic       goodColl_o;
  logic       badColl_o;
  logic       scoreClr;
  logic       moveEn;
  logic [2:0] state;
  logic [6:0] dispScore;
  logic [6:0] highScore;
  logic       isGameComplete;

  modport master (
    output start, pause, frameTick, goodColl_i, badColl_i, curScore,
    input  goodColl_o, badColl_o, scoreClr, moveEn, state, dispScore, highScore,
           isGameComplete
  );

  modport slave (
    input  start, pause, frameTick, goodColl_i, badColl_i, curScore,
    output goodColl_o, badColl_o, scoreClr, moveEn, state, dispScore, highScore,
           isGameComplete
  );
endinterface

// File: rtl/game_ctrl.sv
// Snake game sequencer: game FSM, collision gating, score clear, high score and display select.
// The PAUSE state is built only when GAME_CTRL_PAUSE_EN is defined.
//
// state | meaning
// IDLE  | power-up, showing high score, waiting for start
// PLAY  | snake moving, collisions forwarded to score_tracker
// PAUSE | frozen game, resumed by pause or restarted by start
// OVER  | lost, display blinks score / high score
// WIN   | reached MAX_SCORE, display blinks score / high score
module game_ctrl #(
  parameter int MAX_SCORE   = 50,
  parameter int BLINK_TICKS = 30
) (
  input logic        clk,
  input logic        nRst,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  localparam int            CW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] BLINK_LOAD = CW'(BLINK_TICKS - 1);
  localparam logic [6:0]    MAX_Q      = 7'(MAX_SCORE);

  state_t        state_q, state_n;
  logic          clr_q, clr_n;
  logic [6:0]    high_q, high_n;
  logic [CW-1:0] blink_cnt_q, blink_cnt_n;
  logic          phase_q, phase_n;
  logic          playing;
  logic          done;
  logic          pause_evt;

`ifdef GAME_CTRL_PAUSE_EN
  assign pause_evt = bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign pause_evt    = 1'b0;
`endif

  assign playing = (state_q == S_PLAY);
  assign done    = (state_q == S_OVER) || (state_q == S_WIN);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      clr_q       <= 1'b0;
      high_q      <= 7'd0;
      blink_cnt_q <= BLINK_LOAD;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      clr_q       <= clr_n;
      high_q      <= high_n;
      blink_cnt_q <= blink_cnt_n;
      phase_q     <= phase_n;
    end
  end

  always_comb begin
    state_n = state_q;
    clr_n   = 1'b0;
    case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (bus.start) begin
          state_n = S_PLAY;
          clr_n   = 1'b1;
        end
      end
      S_PLAY: begin
        // The clear cycle still carries the previous game's score, so no win then.
        if (bus.badColl_i)                          state_n = S_OVER;
        else if ((bus.curScore >= MAX_Q) && !clr_q) state_n = S_WIN;
        else if (pause_evt)                         state_n = S_PAUSE;
      end
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (bus.start) begin
          state_n = S_PLAY;
          clr_n   = 1'b1;
        end else if (pause_evt) begin
          state_n = S_PLAY;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    high_n = high_q;
    if (playing && ((state_n == S_OVER) || (state_n == S_WIN)) && (bus.curScore > high_q))
      high_n = bus.curScore;
  end

  // Counter is held at its load value outside OVER/WIN so each entry starts fresh.
  always_comb begin
    blink_cnt_n = blink_cnt_q;
    phase_n     = phase_q;
    if (!done) begin
      blink_cnt_n = BLINK_LOAD;
      phase_n     = 1'b0;
    end else if (bus.frameTick) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_n = BLINK_LOAD;
        phase_n     = ~phase_q;
      end else begin
        blink_cnt_n = blink_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    bus.dispScore = bus.curScore;
    if (state_q == S_IDLE)   bus.dispScore = high_q;
    else if (done && phase_q) bus.dispScore = high_q;
  end

  assign bus.goodColl_o     = playing & bus.goodColl_i & ~bus.badColl_i & ~clr_q;
  assign bus.badColl_o      = playing & bus.badColl_i;
  assign bus.scoreClr       = clr_q;
  assign bus.moveEn         = playing;
  assign bus.state          = state_q;
  assign bus.highScore      = high_q;
  assign bus.isGameComplete = done;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: two instances (default-ish and MAX_SCORE=3) with a
// behavioural score_tracker each; expectations queued at stimulus time and popped at check.
module tb_game_ctrl;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  game_ctrl_if bus_a();
  game_ctrl_if bus_b();

  game_ctrl #(.MAX_SCORE(50), .BLINK_TICKS(4)) dut_a (.clk(clk), .nRst(nRst), .bus(bus_a));
  game_ctrl #(.MAX_SCORE(3),  .BLINK_TICKS(2)) dut_b (.clk(clk), .nRst(nRst), .bus(bus_b));

  // score_tracker stand-ins
  logic [6:0] a_cur, b_cur;
  always @(posedge clk) begin
    if (!nRst)                 a_cur <= 7'd0;
    else if (bus_a.scoreClr)   a_cur <= 7'd0;
    else if (bus_a.goodColl_o) a_cur <= a_cur + 7'd1;
  end
  always @(posedge clk) begin
    if (!nRst)                 b_cur <= 7'd0;
    else if (bus_b.scoreClr)   b_cur <= 7'd0;
    else if (bus_b.goodColl_o) b_cur <= b_cur + 7'd1;
  end
  assign bus_a.curScore = a_cur;
  assign bus_b.curScore = b_cur;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    sb_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic a_good(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.goodColl_i = 1'b1;
      tick();
      bus_a.goodColl_i = 1'b0;
    end
  endtask

  task automatic a_start();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    tick();
  endtask

  task automatic a_frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.frameTick = 1'b1;
      tick();
      bus_a.frameTick = 1'b0;
      tick();
    end
  endtask

  initial begin
    bus_a.start = 0; bus_a.pause = 0; bus_a.frameTick = 0; bus_a.goodColl_i = 0; bus_a.badColl_i = 0;
    bus_b.start = 0; bus_b.pause = 0; bus_b.frameTick = 0; bus_b.goodColl_i = 0; bus_b.badColl_i = 0;

    // reset
    nRst = 1'b0;
    tick(); tick();
    expect_v("rst_state", 0);  check_v(bus_a.state);
    expect_v("rst_high", 0);   check_v(bus_a.highScore);
    expect_v("rst_move", 0);   check_v(bus_a.moveEn);
    expect_v("rst_clr", 0);    check_v(bus_a.scoreClr);
    expect_v("rst_done", 0);   check_v(bus_a.isGameComplete);
    expect_v("rst_disp", 0);   check_v(bus_a.dispScore);
    bus_a.start = 1'b1;
    expect_v("rst_hold_state", 0);
    tick();
    check_v(bus_a.state);
    bus_a.start = 1'b0;
    nRst = 1'b1;
    tick();

    // start from IDLE
    bus_a.start = 1'b1;
    expect_v("start_clr", 1);
    expect_v("start_state", 1);
    expect_v("start_move", 1);
    tick();
    bus_a.start = 1'b0;
    check_v(bus_a.scoreClr);
    check_v(bus_a.state);
    check_v(bus_a.moveEn);
    bus_a.goodColl_i = 1'b1;
    #1;
    expect_v("good_blocked_clr", 0); check_v(bus_a.goodColl_o);
    bus_a.goodColl_i = 1'b0;
    tick();
    expect_v("clr_one_cycle", 0); check_v(bus_a.scoreClr);

    for (int i = 0; i < 3; i++) begin
      bus_a.goodColl_i = 1'b1;
      #1;
      expect_v("good_pass", 1); check_v(bus_a.goodColl_o);
      tick();
      bus_a.goodColl_i = 1'b0;
    end
    expect_v("disp_play", 3); check_v(bus_a.dispScore);

    // game over at 4
    a_good(1);
    bus_a.badColl_i = 1'b1;
    #1;
    expect_v("bad_pass", 1); check_v(bus_a.badColl_o);
    tick();
    bus_a.badColl_i = 1'b0;
    expect_v("over_state", 3); check_v(bus_a.state);
    expect_v("over_done", 1);  check_v(bus_a.isGameComplete);
    expect_v("over_high", 4);  check_v(bus_a.highScore);
    expect_v("over_move", 0);  check_v(bus_a.moveEn);
    expect_v("over_disp", 4);  check_v(bus_a.dispScore);
    bus_a.goodColl_i = 1'b1;
    #1;
    expect_v("good_blocked_over", 0); check_v(bus_a.goodColl_o);
    bus_a.goodColl_i = 1'b0;

    // second game ends lower; high score kept, then blink
    bus_a.start = 1'b1;
    expect_v("restart_clr", 1);
    tick();
    bus_a.start = 1'b0;
    check_v(bus_a.scoreClr);
    tick();
    a_good(2);
    bus_a.badColl_i = 1'b1;
    tick();
    bus_a.badColl_i = 1'b0;
    expect_v("over2_state", 3); check_v(bus_a.state);
    expect_v("high_kept", 4);   check_v(bus_a.highScore);
    expect_v("blink_cur", 2);   check_v(bus_a.dispScore);
    a_frames(3);
    expect_v("blink_before", 2); check_v(bus_a.dispScore);
    a_frames(1);
    expect_v("blink_high", 4);   check_v(bus_a.dispScore);
    a_frames(4);
    expect_v("blink_back", 2);   check_v(bus_a.dispScore);

    // simultaneous collisions at 5
    a_start();
    a_good(5);
    bus_a.goodColl_i = 1'b1;
    bus_a.badColl_i  = 1'b1;
    #1;
    expect_v("sim_good", 0); check_v(bus_a.goodColl_o);
    expect_v("sim_bad", 1);  check_v(bus_a.badColl_o);
    tick();
    bus_a.goodColl_i = 1'b0;
    bus_a.badColl_i  = 1'b0;
    expect_v("sim_state", 3); check_v(bus_a.state);
    expect_v("sim_high", 5);  check_v(bus_a.highScore);

    // start with pause in OVER: start wins
    bus_a.start = 1'b1;
    bus_a.pause = 1'b1;
    tick();
    bus_a.start = 1'b0;
    bus_a.pause = 1'b0;
    expect_v("sp_state", 1); check_v(bus_a.state);
    expect_v("sp_clr", 1);   check_v(bus_a.scoreClr);
    tick();

    // start in PLAY is ignored
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    expect_v("play_start_state", 1); check_v(bus_a.state);
    expect_v("play_start_clr", 0);   check_v(bus_a.scoreClr);

    // pause
    bus_a.pause = 1'b1;
    tick();
    bus_a.pause = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
    expect_v("pause_state", 2); check_v(bus_a.state);
    expect_v("pause_move", 0);  check_v(bus_a.moveEn);
    bus_a.goodColl_i = 1'b1;
    #1;
    expect_v("pause_block", 0); check_v(bus_a.goodColl_o);
    bus_a.goodColl_i = 1'b0;
    bus_a.pause = 1'b1;
    tick();
    bus_a.pause = 1'b0;
    expect_v("resume_state", 1); check_v(bus_a.state);
    expect_v("resume_clr", 0);   check_v(bus_a.scoreClr);
    bus_a.pause = 1'b1;
    tick();
    bus_a.pause = 1'b0;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    expect_v("pstart_state", 1); check_v(bus_a.state);
    expect_v("pstart_clr", 1);   check_v(bus_a.scoreClr);
`else
    expect_v("nopause_state", 1); check_v(bus_a.state);
    expect_v("nopause_move", 1);  check_v(bus_a.moveEn);
    expect_v("nopause_clr", 0);   check_v(bus_a.scoreClr);
`endif

    // win on the MAX_SCORE=3 instance
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus_b.goodColl_i = 1'b1;
      tick();
      bus_b.goodColl_i = 1'b0;
    end
    expect_v("win_pending", 1); check_v(bus_b.state);
    tick();
    expect_v("win_state", 4);   check_v(bus_b.state);
    expect_v("win_high", 3);    check_v(bus_b.highScore);
    expect_v("win_done", 1);    check_v(bus_b.isGameComplete);
    bus_b.goodColl_i = 1'b1;
    #1;
    expect_v("win_block", 0);   check_v(bus_b.goodColl_o);
    bus_b.goodColl_i = 1'b0;

    // reset mid-game discards high score
    tick();
    nRst = 1'b0;
    tick();
    expect_v("midrst_state", 0); check_v(bus_a.state);
    expect_v("midrst_high", 0);  check_v(bus_a.highScore);
    expect_v("midrst_high_b", 0); check_v(bus_b.highScore);
    nRst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
